// File: rtl/udp_img_unpack_if.sv
// Stream bundle between the UDP receiver, the image depacketizer and the pixel write port.
interface udp_img_unpack_if;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic        frame_start;
  logic        frame_done;
  logic        img_wr_en;
  logic [15:0] img_wr_data;
  logic [11:0] line_cnt;
  logic        pkt_err;
  logic        ovf_err;

  modport slave (
    input  rec_en, rec_data, rec_pkt_done, rec_byte_num,
    output frame_start, frame_done, img_wr_en, img_wr_data, line_cnt, pkt_err, ovf_err
  );

  modport master (
    output rec_en, rec_data, rec_pkt_done, rec_byte_num,
    input  frame_start, frame_done, img_wr_en, img_wr_data, line_cnt, pkt_err, ovf_err
  );
endinterface

// File: rtl/udp_img_unpack.sv
// Receive-side image depacketizer: finds the frame header, splits payload words into
// RGB565 pixel pairs and validates each line packet.
//
// state   | meaning
// S_SYNC  | hunting for a header word at the start of a packet
// S_FRAME | header accepted, unpacking and checking line packets
module udp_img_unpack #(
  parameter int          CMOS_H_PIXEL = 640,
  parameter int          CMOS_V_PIXEL = 480,
  parameter logic [31:0] FRAME_HEAD   = 32'hf05a_a50f
) (
  input  logic        clk,
  input  logic        rst_n,
  udp_img_unpack_if.slave bus
);

  localparam logic [15:0] H_PIX    = 16'(CMOS_H_PIXEL);
  localparam logic [11:0] V_PIX    = 12'(CMOS_V_PIXEL);
  localparam logic [15:0] LINE_B   = 16'(CMOS_H_PIXEL * 2);
  localparam logic [15:0] LINE_B_H = 16'(CMOS_H_PIXEL * 2 + 4);

  typedef enum logic {S_SYNC, S_FRAME} state_t;

  state_t      state, state_n;
  logic [15:0] wcnt, wcnt_n;
  logic [15:0] pcnt, pcnt_n;
  logic [11:0] line_q, line_n;
  logic        first, first_n;
  logic        drop, drop_n;
  logic        lo_pend, lo_pend_n;
  logic [15:0] lo_data, lo_data_n;
  logic        ovf_q, ovf_n;
  logic        fs_q, fs_n;
  logic        fd_q, fd_n;
  logic        pe_q, pe_n;
  logic        wr_en_q, wr_en_n;
  logic [15:0] wr_data_q, wr_data_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SYNC;
      wcnt      <= '0;
      pcnt      <= '0;
      line_q    <= '0;
      first     <= 1'b0;
      drop      <= 1'b0;
      lo_pend   <= 1'b0;
      lo_data   <= '0;
      ovf_q     <= 1'b0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      pe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      pcnt      <= pcnt_n;
      line_q    <= line_n;
      first     <= first_n;
      drop      <= drop_n;
      lo_pend   <= lo_pend_n;
      lo_data   <= lo_data_n;
      ovf_q     <= ovf_n;
      fs_q      <= fs_n;
      fd_q      <= fd_n;
      pe_q      <= pe_n;
      wr_en_q   <= wr_en_n;
      wr_data_q <= wr_data_n;
    end
  end

  // Word handling first, then the packet check sees the post-word counters.
  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    pcnt_n    = pcnt;
    line_n    = line_q;
    first_n   = first;
    drop_n    = drop;
    lo_pend_n = 1'b0;
    lo_data_n = lo_data;
    ovf_n     = ovf_q;
    fs_n      = 1'b0;
    fd_n      = 1'b0;
    pe_n      = 1'b0;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data_q;

    if (lo_pend) begin
      wr_en_n   = 1'b1;
      wr_data_n = lo_data;
    end

    if (bus.rec_en) begin
      wcnt_n = wcnt + 16'd1;
      if (lo_pend) begin
        ovf_n  = 1'b1;
        drop_n = 1'b1;
      end else if (wcnt == 16'd0 && bus.rec_data == FRAME_HEAD) begin
        fs_n    = 1'b1;
        pe_n    = (state == S_FRAME);
        line_n  = '0;
        pcnt_n  = '0;
        first_n = 1'b1;
        drop_n  = 1'b0;
        state_n = S_FRAME;
      end else if (state == S_FRAME) begin
        if (pcnt < H_PIX) begin
          wr_en_n   = 1'b1;
          wr_data_n = bus.rec_data[31:16];
          lo_pend_n = 1'b1;
          lo_data_n = bus.rec_data[15:0];
          pcnt_n    = pcnt + 16'd2;
        end else begin
          drop_n = 1'b1;
        end
      end
    end

    if (bus.rec_pkt_done) begin
      if (state_n == S_FRAME) begin
        if (bus.rec_byte_num == (first_n ? LINE_B_H : LINE_B) && pcnt_n == H_PIX && !drop_n) begin
          line_n = line_n + 12'd1;
          pcnt_n = '0;
          if (line_n == V_PIX) begin
            fd_n    = 1'b1;
            state_n = S_SYNC;
          end
        end else begin
          pe_n    = 1'b1;
          state_n = S_SYNC;
        end
      end
      wcnt_n  = '0;
      first_n = 1'b0;
      drop_n  = 1'b0;
    end
  end

  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.pkt_err     = pe_q;
  assign bus.img_wr_en   = wr_en_q;
  assign bus.img_wr_data = wr_data_q;
  assign bus.line_cnt    = line_q;
  assign bus.ovf_err     = ovf_q;

endmodule

// File: tb/tb_udp_img_unpack.sv
// Directed bench for udp_img_unpack on a reduced 4x2 frame geometry.
module tb_udp_img_unpack;
  localparam logic [31:0] HEAD = 32'hf05a_a50f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_fs = 0;
  int   n_fd = 0;
  int   n_pe = 0;
  logic [15:0] pix_q[$];

  udp_img_unpack_if bus();

  udp_img_unpack #(.CMOS_H_PIXEL(4), .CMOS_V_PIXEL(2), .FRAME_HEAD(HEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.img_wr_en) pix_q.push_back(bus.img_wr_data);
      if (bus.frame_start) n_fs++;
      if (bus.frame_done) n_fd++;
      if (bus.pkt_err) n_pe++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the word was sampled, so outputs show T+1.
  task automatic send_word(input logic [31:0] d);
    @(negedge clk);
    bus.rec_en = 1'b1;
    bus.rec_data = d;
    @(negedge clk);
    bus.rec_en = 1'b0;
  endtask

  task automatic send_done(input logic [15:0] nb);
    @(negedge clk);
    bus.rec_pkt_done = 1'b1;
    bus.rec_byte_num = nb;
    @(negedge clk);
    bus.rec_pkt_done = 1'b0;
  endtask

  task automatic clear_counts();
    n_fs = 0;
    n_fd = 0;
    n_pe = 0;
    pix_q.delete();
  endtask

  task automatic chk_pix(input string tag, input logic [15:0] exp[], input int n);
    chk({tag, "_count"}, pix_q.size(), n);
    for (int i = 0; i < n; i++)
      chk(tag, (i < pix_q.size()) ? {16'h0, pix_q[i]} : 32'hdead_beef, {16'h0, exp[i]});
  endtask

  task automatic good_frame();
    send_word(HEAD);
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    send_done(16'd12);
    send_word(32'h5555_6666);
    send_word(32'h7777_8888);
    send_done(16'd8);
  endtask

  initial begin
    logic [15:0] exp_nom[] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                               16'h5555, 16'h6666, 16'h7777, 16'h8888};
    logic [15:0] exp_b2b[] = '{16'hAAAA, 16'hBBBB};

    bus.rec_en = 1'b0;
    bus.rec_data = '0;
    bus.rec_pkt_done = 1'b0;
    bus.rec_byte_num = '0;
    #12;
    chk("rst_wr_en", bus.img_wr_en, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_line", bus.line_cnt, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    chk("rst_pe", bus.pkt_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // nominal frame with step-by-step timing
    clear_counts();
    send_word(HEAD);
    chk("nom_fs_t1", bus.frame_start, 1);
    chk("nom_hdr_nopix", bus.img_wr_en, 0);
    send_word(32'h1111_2222);
    chk("nom_fs_1cyc", bus.frame_start, 0);
    chk("nom_hi_en", bus.img_wr_en, 1);
    chk("nom_hi_data", bus.img_wr_data, 16'h1111);
    @(negedge clk);
    chk("nom_lo_data", bus.img_wr_data, 16'h2222);
    send_word(32'h3333_4444);
    send_done(16'd12);
    chk("nom_line1", bus.line_cnt, 1);
    send_word(32'h5555_6666);
    send_word(32'h7777_8888);
    send_done(16'd8);
    chk("nom_fd_t1", bus.frame_done, 1);
    chk("nom_line2", bus.line_cnt, 2);
    repeat (2) @(negedge clk);
    chk_pix("nom_pix", exp_nom, 8);
    chk("nom_n_fs", n_fs, 1);
    chk("nom_n_fd", n_fd, 1);
    chk("nom_n_pe", n_pe, 0);
    chk("nom_line_hold", bus.line_cnt, 2);

    // garbage while hunting
    clear_counts();
    send_word(32'h1234_5678);
    send_word(HEAD);
    send_done(16'd8);
    repeat (2) @(negedge clk);
    chk("garb_pix", pix_q.size(), 0);
    chk("garb_fs", n_fs, 0);
    chk("garb_pe", n_pe, 0);

    // short second line
    clear_counts();
    send_word(HEAD);
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    send_done(16'd12);
    send_word(32'h5555_6666);
    send_done(16'd4);
    chk("short_pe", bus.pkt_err, 1);
    chk("short_line", bus.line_cnt, 1);
    send_word(32'h9999_aaaa);
    send_done(16'd4);
    repeat (2) @(negedge clk);
    chk("short_sync_pix", pix_q.size(), 6);
    chk("short_fd", n_fd, 0);
    chk("short_n_pe", n_pe, 1);

    // mid-frame restart
    clear_counts();
    send_word(HEAD);
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    send_done(16'd12);
    send_word(HEAD);
    chk("rst_pe_fs", {bus.pkt_err, bus.frame_start}, 2'b11);
    chk("restart_line0", bus.line_cnt, 0);
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    send_done(16'd12);
    chk("restart_line1", bus.line_cnt, 1);
    send_word(32'h5555_6666);
    send_word(32'h7777_8888);
    send_done(16'd8);
    chk("restart_fd", bus.frame_done, 1);
    chk("restart_n_pe", n_pe, 1);
    chk("restart_n_fs", n_fs, 2);

    // back-to-back words overflow the holding register
    send_word(HEAD);
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    send_done(16'd12);
    chk("b2b_pre_ovf", bus.ovf_err, 0);
    clear_counts();
    @(negedge clk);
    bus.rec_en = 1'b1;
    bus.rec_data = 32'hAAAA_BBBB;
    @(negedge clk);
    bus.rec_data = 32'hCCCC_DDDD;
    @(negedge clk);
    bus.rec_en = 1'b0;
    chk("b2b_ovf", bus.ovf_err, 1);
    send_done(16'd8);
    chk("b2b_pe", bus.pkt_err, 1);
    repeat (3) @(negedge clk);
    chk_pix("b2b_pix", exp_b2b, 2);
    chk("b2b_ovf_sticky", bus.ovf_err, 1);
    chk("b2b_fd", n_fd, 0);

    // reset between high and low halfword
    send_word(HEAD);
    send_word(32'h1234_5678);
    chk("rr_hi", bus.img_wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_wr_en", bus.img_wr_en, 0);
    chk("rr_data", bus.img_wr_data, 0);
    chk("rr_ovf", bus.ovf_err, 0);
    chk("rr_line", bus.line_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    good_frame();
    repeat (2) @(negedge clk);
    chk_pix("rr_pix", exp_nom, 8);
    chk("rr_n_fd", n_fd, 1);
    chk("rr_n_pe", n_pe, 0);
    chk("rr_line2", bus.line_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
